// File: rtl/hamming_scrubber.sv
// Scrub engine for a Hamming (7,4) word store: walks every address, writes back
// single-bit corrections, and shares the memory port with a higher-priority host reader.
module hamming_scrubber #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  corr_count,
  output logic [ADDR_W-1:0] last_err_addr,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [3:0]        host_rdata,
  output logic              host_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [6:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [6:0]        mem_wr_data
);

  // state | meaning: IDLE wait start | READ issue scrub read | CHECK syndrome | WRITE write back
  typedef enum logic [1:0] {IDLE, READ, CHECK, WRITE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [6:0]        fix_q;
  logic              rvalid_q;

  function automatic logic [2:0] syndrome(input logic [6:0] cw);
    return {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
            cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
            cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
  endfunction

  function automatic logic [6:0] correct(input logic [6:0] cw);
    logic [2:0] s;
    logic [6:0] flip;
    s = syndrome(cw);
    flip = '0;
    for (int i = 0; i < 7; i++) flip[i] = (s == 3'(i + 1));
    return cw ^ flip;
  endfunction

  logic [2:0] syn_rd;
  logic [6:0] fix_rd;
  logic       last_addr;
  logic       host_acc;

  assign syn_rd    = syndrome(mem_rd_data);
  assign fix_rd    = correct(mem_rd_data);
  assign last_addr = (addr_q == '1);
  assign host_acc  = host_req && (state_q == IDLE || state_q == READ);

  assign host_ready    = host_acc;
  assign mem_rd_en     = host_acc || (state_q == READ && !host_req);
  assign mem_addr      = host_acc ? host_addr : addr_q;
  // Write strobe is masked by reset so an abort in WRITE never commits the word.
  assign mem_wr_en     = (state_q == WRITE) && !rst;
  assign mem_wr_data   = fix_q;
  assign busy          = (state_q != IDLE);
  assign done          = !rst && last_addr &&
                         ((state_q == CHECK && syn_rd == 3'd0) || state_q == WRITE);
  assign host_rvalid   = rvalid_q;
  assign host_rdata    = rvalid_q ? {fix_rd[6], fix_rd[5], fix_rd[4], fix_rd[2]} : 4'd0;
  assign host_err      = rvalid_q && (syn_rd != 3'd0);
  assign corr_count    = cnt_q;
  assign last_err_addr = last_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      last_err_q <= '0;
      cnt_q      <= '0;
      fix_q      <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      rvalid_q <= host_acc;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          if (!host_req) state_q <= CHECK;
        end
        CHECK: begin
          if (syn_rd != 3'd0) begin
            fix_q   <= fix_rd;
            state_q <= WRITE;
          end else if (last_addr) begin
            state_q <= IDLE;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= READ;
          end
        end
        WRITE: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          last_err_q <= addr_q;
          if (last_addr) begin
            state_q <= IDLE;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= READ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_scrubber.sv
// Bench for hamming_scrubber: behavioural memory, Hamming model by bit positions,
// per-cycle host-response checking and directed scrub-pass scenarios.
module tb_hamming_scrubber;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, host_req;
  logic [AW-1:0] host_addr;
  logic          busy, done, host_ready, host_rvalid, host_err, mem_rd_en, mem_wr_en;
  logic [7:0]    corr_count;
  logic [AW-1:0] last_err_addr, mem_addr;
  logic [3:0]    host_rdata;
  logic [6:0]    mem_rd_data, mem_wr_data;

  logic          start_s, host_req_s;
  logic [AW-1:0] host_addr_s;
  logic          busy_s, done_s, host_ready_s, host_rvalid_s, host_err_s, mem_rd_en_s, mem_wr_en_s;
  logic [1:0]    corr_count_s;
  logic [AW-1:0] last_err_addr_s, mem_addr_s;
  logic [3:0]    host_rdata_s;
  logic [6:0]    mem_rd_data_s, mem_wr_data_s;

  hamming_scrubber #(.ADDR_W(AW), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .corr_count(corr_count), .last_err_addr(last_err_addr),
    .host_req(host_req), .host_addr(host_addr), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data));

  hamming_scrubber #(.ADDR_W(AW), .CNT_W(2)) u_dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
    .corr_count(corr_count_s), .last_err_addr(last_err_addr_s),
    .host_req(host_req_s), .host_addr(host_addr_s), .host_ready(host_ready_s),
    .host_rvalid(host_rvalid_s), .host_rdata(host_rdata_s), .host_err(host_err_s),
    .mem_addr(mem_addr_s), .mem_rd_en(mem_rd_en_s), .mem_rd_data(mem_rd_data_s),
    .mem_wr_en(mem_wr_en_s), .mem_wr_data(mem_wr_data_s));

  // Synchronous memories; contents are (re)loaded from *_init when load is pulsed.
  logic [6:0]    mem [DEPTH];
  logic [6:0]    mem_init [DEPTH];
  logic [6:0]    mem_s [DEPTH];
  logic [6:0]    mem_s_init [DEPTH];
  logic          load, load_s;
  int            wr_cnt, scrub_rd_cnt, wr_cnt_s;
  logic [AW-1:0] wr_addr_log [64];
  logic [6:0]    wr_data_log [64];
  logic [AW-1:0] first_rd_addr;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_init[i];
      wr_cnt       <= 0;
      scrub_rd_cnt <= 0;
      mem_rd_data  <= '0;
    end else begin
      if (mem_rd_en) begin
        mem_rd_data <= mem[mem_addr];
        if (!host_ready) begin
          if (scrub_rd_cnt == 0) first_rd_addr <= mem_addr;
          scrub_rd_cnt <= scrub_rd_cnt + 1;
        end
      end
      if (mem_wr_en) begin
        mem[mem_addr] <= mem_wr_data;
        if (wr_cnt < 64) begin
          wr_addr_log[wr_cnt] <= mem_addr;
          wr_data_log[wr_cnt] <= mem_wr_data;
        end
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (load_s) begin
      for (int i = 0; i < DEPTH; i++) mem_s[i] <= mem_s_init[i];
      wr_cnt_s      <= 0;
      mem_rd_data_s <= '0;
    end else begin
      if (mem_rd_en_s) mem_rd_data_s <= mem_s[mem_addr_s];
      if (mem_wr_en_s) begin
        mem_s[mem_addr_s] <= mem_wr_data_s;
        wr_cnt_s <= wr_cnt_s + 1;
      end
    end
  end

  // Model: syndrome is the XOR of the 1-based positions of all set bits.
  function automatic int m_syn(input logic [6:0] cw);
    int s = 0;
    for (int p = 1; p <= 7; p++) if (cw[p-1]) s ^= p;
    return s;
  endfunction

  function automatic logic [6:0] m_fix(input logic [6:0] cw);
    int s = m_syn(cw);
    logic [6:0] r = cw;
    if (s != 0) r[s-1] = ~r[s-1];
    return r;
  endfunction

  function automatic logic [3:0] m_data(input logic [6:0] cw);
    return {cw[6], cw[5], cw[4], cw[2]};
  endfunction

  int n_checks = 0;
  int n_fail   = 0;
  int rv_cnt, rv_b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; captures any host accept at the edge and checks its response after it.
  task automatic tick();
    logic       acc;
    logic [6:0] cw;
    @(posedge clk);
    acc = host_req && host_ready && !rst;
    cw  = mem[host_addr];
    @(negedge clk);
    chk("host_rvalid", host_rvalid, acc);
    if (acc) begin
      chk("host_rdata", host_rdata, m_data(m_fix(cw)));
      chk("host_err", host_err, m_syn(cw) != 0);
      rv_cnt++;
      if (host_rdata == 4'hB && host_err) rv_b1++;
    end
    chk("rd_wr_exclusive", mem_rd_en && mem_wr_en, 0);
  endtask

  task automatic chk_reset_vals();
    chk("reset_flags", {busy, done, host_ready, host_rvalid, host_err, mem_rd_en, mem_wr_en}, 0);
    chk("reset_corr_count", corr_count, 0);
    chk("reset_last_err_addr", last_err_addr, 0);
    chk("reset_host_rdata", host_rdata, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wr_data", mem_wr_data, 0);
  endtask

  task automatic prep();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic fill_clean();
    for (int i = 0; i < DEPTH; i++) mem_init[i] = 7'h55;
  endtask

  // Launches a pass from idle and returns cycles from start-accept to done.
  task automatic run_pass(input int host_at, input int start_at, input bit start_on_done,
                          output int len);
    len = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      if (n == 1) chk("busy_after_start", busy, 1);
      if (done) begin
        len = n;
        break;
      end
      if (host_at != 0 && n == host_at) begin
        host_req  = 1'b1;
        host_addr = 4'd5;
      end
      if (host_at != 0 && n == host_at + 3) host_req = 1'b0;
      start = (n == start_at);
      tick();
    end
    host_req = 1'b0;
    chk("done_seen", len != 0, 1);
    chk("busy_at_done", busy, 1);
    if (start_on_done) start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_drop_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    tick();
    chk("stay_idle", busy, 0);
  endtask

  // Writes must be exactly the corrupted addresses, in order, with corrected words.
  task automatic chk_writes();
    int k = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (m_syn(mem_init[a]) != 0) begin
        chk("wr_addr", wr_addr_log[k], a);
        chk("wr_data", wr_data_log[k], m_fix(mem_init[a]));
        k++;
      end
      chk("mem_after_pass", mem[a], m_fix(mem_init[a]));
    end
    chk("wr_count", wr_cnt, k);
    chk("scrub_reads", scrub_rd_cnt, DEPTH);
  endtask

  int len;

  initial begin
    rst = 1'b1; start = 1'b0; host_req = 1'b0; host_addr = '0;
    start_s = 1'b0; host_req_s = 1'b0; host_addr_s = '0;
    load = 1'b0; load_s = 1'b0;
    rv_cnt = 0; rv_b1 = 0;
    fill_clean();
    for (int i = 0; i < DEPTH; i++) mem_s_init[i] = 7'h55;

    chk("model_syn_45", m_syn(7'h45), 5);
    chk("model_fix_45", m_fix(7'h45), 7'h55);
    chk("model_data_55", m_data(7'h55), 4'hB);

    load = 1'b1; load_s = 1'b1;
    tick(); tick();
    load = 1'b0; load_s = 1'b0;
    chk_reset_vals();
    rst = 1'b0;
    tick();

    // Clean memory
    fill_clean();
    prep();
    run_pass(0, 0, 0, len);
    chk("clean_len", len, 32);
    chk("clean_corr_count", corr_count, 0);
    chk_writes();

    // Single error at address 5
    mem_init[5] = 7'h45;
    prep();
    run_pass(0, 0, 0, len);
    chk("err5_len", len, 33);
    chk("err5_corr_count", corr_count, 1);
    chk("err5_last_err_addr", last_err_addr, 5);
    chk_writes();

    // Host reads of address 5 while the pass runs
    prep();
    rv_cnt = 0; rv_b1 = 0;
    run_pass(3, 0, 0, len);
    chk("host_len", len, 36);
    chk("host_resp_count", rv_cnt, 3);
    chk("host_resp_b_err", rv_b1, 3);
    chk_writes();

    // Reset during the write-back of address 5
    prep();
    start = 1'b1;
    tick();
    start = 1'b0;
    len = 0;
    for (int n = 1; n <= 100; n++) begin
      if (mem_wr_en) begin
        len = n;
        break;
      end
      tick();
    end
    chk("abort_write_seen", len, 13);
    chk("abort_write_addr", mem_addr, 5);
    rst = 1'b1;
    tick();
    chk_reset_vals();
    chk("abort_no_write", wr_cnt, 0);
    chk("abort_mem5", mem[5], 7'h45);
    rst = 1'b0;
    prep();
    run_pass(0, 0, 0, len);
    chk("restart_len", len, 33);
    chk("restart_first_addr", first_rd_addr, 0);
    chk_writes();

    // start pulsed mid-pass and again on done: both ignored
    fill_clean();
    mem_init[3] = 7'h54;
    prep();
    run_pass(0, 20, 1, len);
    chk("midstart_len", len, 33);
    chk("midstart_corr_count", corr_count, 1);
    chk("midstart_last_err_addr", last_err_addr, 3);
    chk_writes();

    // Saturating counter, narrow instance
    mem_s_init[1]  = 7'h54;
    mem_s_init[4]  = 7'h51;
    mem_s_init[9]  = 7'h15;
    mem_s_init[14] = 7'h5D;
    load_s = 1'b1;
    tick();
    load_s = 1'b0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    len = 0;
    for (int n = 1; n <= 300; n++) begin
      if (done_s) begin
        len = n;
        break;
      end
      tick();
    end
    tick();
    chk("sat_len", len, 36);
    chk("sat_corr_count", corr_count_s, 3);
    chk("sat_last_err_addr", last_err_addr_s, 14);
    chk("sat_wr_count", wr_cnt_s, 4);
    for (int a = 0; a < DEPTH; a++) chk("sat_mem", mem_s[a], 7'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_scrubber.md
# hamming_scrubber

Memory scrub controller for a Hamming (7,4)-protected word store. On `start` it walks every address of an external synchronous memory of 7-bit codewords. For each word it computes the syndrome and writes back the corrected codeword when the syndrome is non-zero. It also arbitrates the single memory port between the scrub engine and a host read channel; the host always has priority and receives corrected 4-bit data.

## Interface
- `ADDR_W`, default 4: memory address width; depth is 2**ADDR_W.
- `CNT_W`, default 8: width of the correction counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one scrub pass; ignored while `busy`.
- `busy`  out  1  scrub pass in progress.
- `done`  out  1  one-cycle pulse at end of pass.
- `corr_count`  out  CNT_W  corrections in current/last pass; saturating.
- `last_err_addr`  out  ADDR_W  address of most recent scrub correction.
- `host_req`  in  1  host read request.
- `host_addr`  in  ADDR_W  host read address.
- `host_ready`  out  1  host request accepted this cycle.
- `host_rvalid`  out  1  host read data valid.
- `host_rdata`  out  4  corrected data {cw[6],cw[5],cw[4],cw[2]}.
- `host_err`  out  1  syndrome non-zero on the host read.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_rd_data`  in  7  codeword; valid the cycle after `mem_rd_en`.
- `mem_wr_en`  out  1  memory write strobe.
- `mem_wr_data`  out  7  corrected codeword to write.

## Operation
- Codeword bit i holds Hamming position i+1: p1=cw[0], p2=cw[1], d1=cw[2], p3=cw[3], d2=cw[4], d3=cw[5], d4=cw[6].
- Syndrome bits: s0=cw0^cw2^cw4^cw6, s1=cw1^cw2^cw5^cw6, s2=cw3^cw4^cw5^cw6. A non-zero syndrome S means bit S-1 is inverted to correct the word.
- Double-bit errors are miscorrected. This is inherent to (7,4) and is not flagged separately.
- FSM states: IDLE, READ, CHECK, WRITE.
  - IDLE: `start`=1 clears `corr_count` and sets scrub address 0, then goes to READ.
  - READ: if `host_req`=1, serve the host and stay in READ (stall). Otherwise drive `mem_rd_en`=1 with `mem_addr`=scrub address and go to CHECK.
  - CHECK: evaluate `mem_rd_data`.
    - Syndrome non-zero: register the corrected word and go to WRITE.
    - Syndrome zero: if scrub address is the last, pulse `done` and go to IDLE; otherwise increment the address and go to READ.
  - WRITE: drive `mem_wr_en`=1 with `mem_addr`=scrub address and `mem_wr_data`=corrected word. Increment `corr_count`, saturating at all-ones. Load `last_err_addr`. Then advance exactly as a clean CHECK does.
- Host arbitration:
  - `host_ready`=`host_req` in IDLE and READ; 0 in CHECK and WRITE.
  - An accepted request drives `mem_rd_en`=1 with `mem_addr`=`host_addr`.
  - Host reads never write back and never touch the counters.
- `start` while `busy` is ignored. `start` in the same cycle as the `done` pulse is also ignored, because the FSM is still busy in that cycle.
- `rst` mid-pass aborts immediately: no write is issued, and the FSM returns to IDLE.

## Timing
- Reset values: `busy`, `done`, `host_ready`, `host_rvalid`, `host_err`, `mem_rd_en`, `mem_wr_en` = 0. `corr_count`, `last_err_addr`, `host_rdata`, `mem_addr`, `mem_wr_data` = 0. State = IDLE.
- `busy`=1 from the cycle after `start` is accepted through the cycle `done` pulses. It drops to 0 the cycle after `done`.
- Host: request accepted at cycle N gives `host_rvalid`=1 for one cycle at N+1, with registered `host_rdata`/`host_err`. Back-to-back accepts give back-to-back responses.
- Scrub cost per word: 2 cycles when clean, 3 when corrected, plus one cycle per host read taken in READ.
- Clean pass with no host traffic: `done` pulses 2*2**ADDR_W cycles after the start-accept cycle.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.
- Address wraps only by completing the pass; the scrub address never exceeds 2**ADDR_W-1.

## Test plan
- Memory all 7'h55 (data 4'hB), `start` -> 16 reads, no writes; `done` 32 cycles after accept; `corr_count`=0.
- Addr 5 = 7'h45 (bit 4 flipped, syndrome 5), rest 7'h55 -> exactly one write at addr 5 with 7'h55; `corr_count`=1, `last_err_addr`=5; pass length 33 cycles.
- Pass running, `host_req` held 3 cycles at addr 5 = 7'h45:
  - scrub stalls 3 cycles;
  - each response is `host_rdata`=4'hB, `host_err`=1;
  - the host read causes no write.
- CNT_W=2, four corrupted words -> `corr_count` saturates at 3; all four words written back.
- `rst` asserted in the WRITE cycle of addr 5 -> no further `mem_wr_en`; all outputs at reset values the next cycle; a new `start` scrubs from addr 0.
- `start` re-asserted mid-pass -> ignored: `corr_count` is not cleared and the pass length is unchanged.
